// File: rtl/debug_mem_reader_if.sv
// debug_mem_reader_if: memory read port plus valid/ready dump stream used by
// debug_mem_reader. The reader is the master on both; the memory and the
// dump consumer together form the slave side.
interface debug_mem_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output mem_rd, mem_addr,
    input  mem_rd_data,
    output dump_valid, dump_addr, dump_data,
    input  dump_ready
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_rd_data,
    input  dump_valid, dump_addr, dump_data,
    output dump_ready
  );
endinterface

// File: rtl/debug_mem_reader.sv
// debug_mem_reader: reads a contiguous range of data memory back out after a
// run while the core is held in debug. One read is outstanding at a time:
// issue, wait the fixed read latency, present the word until accepted.
// Optional feature: define DEBUG_MEM_READER_CHECKSUM_EN to add a running
// checksum output summed over every accepted dump word.
module debug_mem_reader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_debug,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
`ifdef DEBUG_MEM_READER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  debug_mem_reader_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] PRESENT = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  // RD_LATENCY is at most 4, so the countdown never exceeds 3.
  localparam int              LAT_W    = 2;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              dv_q, dv_d;
  logic [ADDR_W-1:0] da_q, da_d;
  logic [DATA_W-1:0] dd_q, dd_d;

  logic accept;
  logic abort;
  logic hs;

  assign busy   = (state_q == ISSUE) || (state_q == WAIT) || (state_q == PRESENT);
  assign done   = (state_q == FINISH);
  assign accept = (state_q == IDLE) && start && enable_debug;
  // Losing debug mode mid-dump discards everything, including a word on offer.
  assign abort  = busy && !enable_debug;
  assign hs     = (state_q == PRESENT) && dv_q && bus.dump_ready && enable_debug;

  assign bus.mem_rd     = (state_q == ISSUE);
  assign bus.mem_addr   = (state_q == ISSUE) ? cur_q : '0;
  assign bus.dump_valid = dv_q;
  assign bus.dump_addr  = da_q;
  assign bus.dump_data  = dd_q;

  // Next-state logic for the dump sequencer and its counters.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    dv_d    = dv_q;
    da_d    = da_q;
    dd_d    = dd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_d   = base_addr;
          rem_d   = word_count;
          state_d = (word_count == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          dv_d    = 1'b1;
          da_d    = cur_q;
          dd_d    = bus.mem_rd_data;
          state_d = PRESENT;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      PRESENT: begin
        if (hs) begin
          dv_d    = 1'b0;
          cur_d   = cur_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == {{ADDR_W{1'b0}}, 1'b1}) ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      cur_d   = '0;
      rem_d   = '0;
      lat_d   = '0;
      dv_d    = 1'b0;
      da_d    = '0;
      dd_d    = '0;
    end
  end

  // State and datapath registers; reset returns every output to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      dv_q    <= 1'b0;
      da_q    <= '0;
      dd_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      dv_q    <= dv_d;
      da_q    <= da_d;
      dd_q    <= dd_d;
    end
  end

`ifdef DEBUG_MEM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Running sum of accepted words, restarted by each accepted start.
  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      csum_d = '0;
    end else if (hs) begin
      csum_d = csum_q + dd_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_debug_mem_reader.sv
// tb_debug_mem_reader: randomized bench for debug_mem_reader with a
// behavioural memory and an address/data stream model.
module tb_debug_mem_reader;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int RDL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable_debug = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done;
`ifdef DEBUG_MEM_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  debug_mem_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  debug_mem_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_debug (enable_debug),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .busy         (busy),
    .done         (done),
`ifdef DEBUG_MEM_READER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Data memory as filled by the debug write path; read data appears RDL
  // cycles after mem_rd and is garbage otherwise.
  logic [DW-1:0] mem [512];
  logic [DW-1:0] rd_pipe [RDL];
  bit            vld_pipe [RDL];
  always @(posedge clk) begin
    rd_pipe[0]  <= mem[bus.mem_addr];
    vld_pipe[0] <= bus.mem_rd;
    for (int k = 1; k < RDL; k++) begin
      rd_pipe[k]  <= rd_pipe[k-1];
      vld_pipe[k] <= vld_pipe[k-1];
    end
  end
  assign bus.mem_rd_data = vld_pipe[RDL-1] ? rd_pipe[RDL-1] : 32'hBAD0_0BAD;

  int checks = 0;
  int errors = 0;

  // Observations gathered by run_dump.
  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  logic [AW-1:0] rd_addr  [$];
  int            issue_cyc [$];
  int            rise_cyc  [$];
  int            hs_cyc    [$];
  int            done_cnt, done_cyc, hold_viol, busy_hi;
  logic          busy_at_done;
  logic [53:0]   pa_vec;

  // Pulses start at cycle 0 and records cycle-by-cycle behaviour. Optional
  // stall of one word, random ready, an abort (1 = reset, 2 = enable drop)
  // and a second start while busy.
  task automatic run_dump(input logic [AW-1:0] base, input logic [AW:0] cnt,
                          input int stall_word, input int stall_len, input bit rnd_ready,
                          input int max_cyc, input int abort_kind, input int abort_at,
                          input int busy_start_at);
    bit            prev_v = 0, prev_r = 0;
    logic [AW-1:0] prev_a = '0;
    logic [DW-1:0] prev_d = '0;
    int            stall_ctr = 0;
    int            after_done = -1;
    obs_addr.delete(); obs_data.delete(); rd_addr.delete();
    issue_cyc.delete(); rise_cyc.delete(); hs_cyc.delete();
    done_cnt = 0; done_cyc = -1; hold_viol = 0; busy_hi = 0; busy_at_done = 1'b0; pa_vec = '1;
    @(negedge clk);
    base_addr = base; word_count = cnt; start = 1'b1; bus.dump_ready = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rnd_ready) bus.dump_ready = 1'($urandom_range(0, 1));
      else if (bus.dump_valid && obs_addr.size() == stall_word && stall_ctr < stall_len) begin
        bus.dump_ready = 1'b0; stall_ctr++;
      end else bus.dump_ready = 1'b1;
      if (bus.mem_rd) begin rd_addr.push_back(bus.mem_addr); issue_cyc.push_back(c); end
      if (bus.dump_valid && !prev_v) rise_cyc.push_back(c);
      if (abort_kind == 0 && prev_v && !prev_r &&
          (!bus.dump_valid || bus.dump_addr !== prev_a || bus.dump_data !== prev_d)) hold_viol++;
      if (bus.dump_valid && bus.dump_ready) begin
        obs_addr.push_back(bus.dump_addr); obs_data.push_back(bus.dump_data); hs_cyc.push_back(c);
      end
      if (busy) busy_hi++;
      if (done) begin done_cnt++; done_cyc = c; busy_at_done = busy; after_done = 0; end
      else if (after_done >= 0) after_done++;
      prev_v = bus.dump_valid; prev_r = bus.dump_ready;
      prev_a = bus.dump_addr;  prev_d = bus.dump_data;
      if (abort_kind != 0 && c == abort_at + 1) begin
        pa_vec = {busy, done, bus.mem_rd, bus.dump_valid, bus.mem_addr, bus.dump_addr, bus.dump_data};
        reset = 1'b0; enable_debug = 1'b1;
      end
      if (abort_kind == 1 && c == abort_at) reset = 1'b1;
      if (abort_kind == 2 && c == abort_at) enable_debug = 1'b0;
      if (c == busy_start_at) begin
        start = 1'b1; base_addr = base + 9'd100; word_count = 10'd7;
      end
      if (after_done == 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    bus.dump_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, bus.mem_rd, bus.dump_valid, bus.mem_addr, bus.dump_addr, bus.dump_data} !== 54'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b v=%b ma=%0d da=%0d dd=%h, want all 0",
               busy, done, bus.mem_rd, bus.dump_valid, bus.mem_addr, bus.dump_addr, bus.dump_data);
    end
`ifdef DEBUG_MEM_READER_CHECKSUM_EN
    checks++;
    if (checksum !== 32'd0) begin errors++; $display("FAIL reset_checksum: got %h want 0", checksum); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    mem[0] = 32'h0000_8F00; mem[1] = 32'h0000_00FF;
    run_dump(9'd0, 10'd2, -1, 0, 1'b0, 60, 0, 0, 0);
    checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 9'd0 || obs_data[0] !== 32'h8F00 ||
        obs_addr[1] !== 9'd1 || obs_data[1] !== 32'hFF) begin
      errors++; $display("FAIL basic_stream: got %0d words, want (0,8f00),(1,ff)", obs_addr.size());
    end
    checks++;
    if (done_cnt != 1 || hs_cyc.size() != 2 || done_cyc != hs_cyc[1] + 1) begin
      errors++; $display("FAIL basic_done: got count %0d at cycle %0d, want one pulse after last handshake", done_cnt, done_cyc);
    end
    checks++;
    if (busy_at_done !== 1'b0 || busy_hi != done_cyc - 1) begin
      errors++; $display("FAIL basic_busy: got busy_at_done=%b high_cycles=%0d, want 0 and %0d", busy_at_done, busy_hi, done_cyc - 1);
    end
    checks++;
    if (issue_cyc.size() != 2 || issue_cyc[1] - issue_cyc[0] != RDL + 2) begin
      errors++; $display("FAIL basic_throughput: got %0d reads, want 2 spaced %0d cycles", issue_cyc.size(), RDL + 2);
    end
`ifdef DEBUG_MEM_READER_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h0000_8FFF) begin errors++; $display("FAIL basic_checksum: got %h want 00008fff", checksum); end
`endif
  endtask

  task automatic test_latency();
    run_dump(9'd5, 10'd1, -1, 0, 1'b0, 40, 0, 0, 0);
    checks++;
    if (rd_addr.size() != 1 || rd_addr[0] !== 9'd5 || issue_cyc[0] != 1) begin
      errors++; $display("FAIL latency_issue: got %0d reads, want one read of addr 5 at cycle 1", rd_addr.size());
    end
    checks++;
    if (rise_cyc.size() != 1 || rise_cyc[0] - 1 != RDL + 1) begin
      errors++; $display("FAIL latency_valid: got rise at cycle %0d, want cycle %0d", (rise_cyc.size() > 0) ? rise_cyc[0] : -1, RDL + 2);
    end
    checks++;
    if (obs_data.size() != 1 || obs_data[0] !== mem[5]) begin
      errors++; $display("FAIL latency_data: got %0d words, want mem[5]=%h", obs_data.size(), mem[5]);
    end
  endtask

  task automatic test_backpressure();
    run_dump(9'd0, 10'd3, 1, 5, 1'b0, 80, 0, 0, 0);
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles, want 0", hold_viol); end
    checks++;
    if (rd_addr.size() != 3) begin errors++; $display("FAIL bp_reads: got %0d reads, want 3", rd_addr.size()); end
    checks++;
    if (obs_addr.size() != 3 || obs_addr[0] !== 9'd0 || obs_addr[1] !== 9'd1 || obs_addr[2] !== 9'd2 ||
        obs_data[0] !== mem[0] || obs_data[1] !== mem[1] || obs_data[2] !== mem[2]) begin
      errors++; $display("FAIL bp_order: got %0d words, want addresses 0,1,2 with memory data", obs_addr.size());
    end
    checks++;
    if (hs_cyc.size() != 3 || rise_cyc.size() != 3 || hs_cyc[1] - rise_cyc[1] != 5) begin
      errors++; $display("FAIL bp_stall: got stall length mismatch, want word 1 accepted 5 cycles after valid");
    end
  endtask

  task automatic test_wrap();
    run_dump(9'd510, 10'd3, -1, 0, 1'b0, 60, 0, 0, 0);
    checks++;
    if (obs_addr.size() != 3 || obs_addr[0] !== 9'd510 || obs_addr[1] !== 9'd511 || obs_addr[2] !== 9'd0 ||
        obs_data[0] !== mem[510] || obs_data[1] !== mem[511] || obs_data[2] !== mem[0]) begin
      errors++; $display("FAIL wrap_stream: got %0d words, want addresses 510,511,0", obs_addr.size());
    end
`ifdef DEBUG_MEM_READER_CHECKSUM_EN
    checks++;
    if (checksum !== 32'(mem[510] + mem[511] + mem[0])) begin
      errors++; $display("FAIL wrap_checksum: got %h want %h", checksum, 32'(mem[510] + mem[511] + mem[0]));
    end
`endif
  endtask

  task automatic test_empty();
    run_dump(9'd33, 10'd0, -1, 0, 1'b0, 20, 0, 0, 0);
    checks++;
    if (rd_addr.size() != 0 || obs_addr.size() != 0) begin
      errors++; $display("FAIL empty_reads: got %0d reads %0d words, want 0 and 0", rd_addr.size(), obs_addr.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 1) begin
      errors++; $display("FAIL empty_done: got %0d pulses at cycle %0d, want 1 at cycle 1", done_cnt, done_cyc);
    end
  endtask

  task automatic test_no_enable();
    enable_debug = 1'b0;
    run_dump(9'd7, 10'd4, -1, 0, 1'b0, 15, 0, 0, 0);
    enable_debug = 1'b1;
    checks++;
    if (rd_addr.size() != 0 || rise_cyc.size() != 0 || done_cnt != 0 || busy_hi != 0) begin
      errors++; $display("FAIL no_enable: got reads=%0d valids=%0d done=%0d busy=%0d, want all 0",
                         rd_addr.size(), rise_cyc.size(), done_cnt, busy_hi);
    end
  endtask

  task automatic test_start_busy();
    run_dump(9'd20, 10'd3, -1, 0, 1'b0, 60, 0, 0, 4);
    checks++;
    if (obs_addr.size() != 3 || obs_addr[0] !== 9'd20 || obs_addr[1] !== 9'd21 || obs_addr[2] !== 9'd22 ||
        rd_addr.size() != 3 || done_cnt != 1) begin
      errors++; $display("FAIL start_busy: got %0d words %0d reads %0d done, want 3, 3, 1 from base 20",
                         obs_addr.size(), rd_addr.size(), done_cnt);
    end
  endtask

  task automatic test_abort_reset();
    run_dump(9'd40, 10'd4, -1, 0, 1'b0, 15, 1, 3, 0);
    checks++;
    if (pa_vec !== 54'd0 || done_cnt != 0 || rd_addr.size() != 1) begin
      errors++; $display("FAIL abort_reset: got outputs %h done=%0d reads=%0d, want 0, 0, 1", pa_vec, done_cnt, rd_addr.size());
    end
    run_dump(9'd60, 10'd2, -1, 0, 1'b0, 60, 0, 0, 0);
    checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 9'd60 || obs_addr[1] !== 9'd61 ||
        obs_data[0] !== mem[60] || obs_data[1] !== mem[61] || done_cnt != 1) begin
      errors++; $display("FAIL abort_reset_rerun: got %0d words %0d done, want 60,61 and 1", obs_addr.size(), done_cnt);
    end
  endtask

  task automatic test_abort_enable();
    run_dump(9'd40, 10'd4, 0, 20, 1'b0, 15, 2, 8, 0);
    checks++;
    if (pa_vec !== 54'd0 || done_cnt != 0 || obs_addr.size() != 0 || rd_addr.size() != 1) begin
      errors++; $display("FAIL abort_enable: got outputs %h done=%0d words=%0d, want 0, 0, 0", pa_vec, done_cnt, obs_addr.size());
    end
    run_dump(9'd300, 10'd2, -1, 0, 1'b0, 60, 0, 0, 0);
    checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 9'd300 || obs_addr[1] !== 9'd301 ||
        obs_data[0] !== mem[300] || obs_data[1] !== mem[301] || done_cnt != 1) begin
      errors++; $display("FAIL abort_enable_rerun: got %0d words %0d done, want 300,301 and 1", obs_addr.size(), done_cnt);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] b, ea;
    logic [AW:0]   n;
    logic [DW-1:0] sum;
    int            bad, exp_done;
    for (int it = 0; it < 13; it++) begin
      b = AW'($urandom);
      n = (it == 12) ? 10'd515 : 10'($urandom_range(0, 10));
      run_dump(b, n, -1, 0, (it != 12), int'(n) * 20 + 30, 0, 0, 0);
      bad = 0; sum = '0;
      for (int i = 0; i < int'(n); i++) begin
        ea  = AW'((int'(b) + i) % 512);
        sum = sum + mem[ea];
        if (i >= obs_addr.size() || obs_addr[i] !== ea || obs_data[i] !== mem[ea]) bad++;
        if (i >= rd_addr.size() || rd_addr[i] !== ea) bad++;
        if (i < rise_cyc.size() && i < issue_cyc.size() && rise_cyc[i] - issue_cyc[i] != RDL + 1) bad++;
      end
      checks++;
      if (bad != 0 || obs_addr.size() != int'(n) || rd_addr.size() != int'(n) || hold_viol != 0) begin
        errors++; $display("FAIL random_stream[%0d]: base %0d count %0d got %0d words %0d reads %0d bad %0d unstable",
                           it, b, n, obs_addr.size(), rd_addr.size(), bad, hold_viol);
      end
      exp_done = (n == 0) ? 1 : ((hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] + 1 : -2);
      checks++;
      if (done_cnt != 1 || done_cyc != exp_done) begin
        errors++; $display("FAIL random_done[%0d]: got %0d pulses at %0d, want 1 at %0d", it, done_cnt, done_cyc, exp_done);
      end
`ifdef DEBUG_MEM_READER_CHECKSUM_EN
      checks++;
      if (checksum !== sum) begin errors++; $display("FAIL random_checksum[%0d]: got %h want %h", it, checksum, sum); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_wrap();
    test_empty();
    test_no_enable();
    test_start_busy();
    test_abort_reset();
    test_abort_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
